// File: rtl/dm_mem_port_arbiter_pkg.sv
// Shared types and constants for the debug-memory port arbiter.
// Holds the region size, read latency, grant encoding and per-port state encoding.
package dm_pkg;

  localparam logic [31:0] DM_REGION_SIZE  = 32'h0000_1000;
  localparam int unsigned DM_READ_LATENCY = 32'd1;

  typedef enum logic {
    GNT_IFETCH = 1'b0,
    GNT_DMEM   = 1'b1
  } grant_e;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    PENDING  = 2'd1,
    INFLIGHT = 2'd2
  } port_state_e;

endpackage

// File: rtl/dm_mem_port_arbiter_slot.sv
// One-entry request holding slot for a strobe-style master.
// Presents either the held request or the fresh strobe as this port's candidate.
module dm_req_slot
  import dm_pkg::*;
#(
  parameter int unsigned BusWidth = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  strobe_i,
  input  logic                  we_i,
  input  logic [BusWidth-1:0]   addr_i,
  input  logic [BusWidth-1:0]   wdata_i,
  input  logic [BusWidth/8-1:0] be_i,
  input  logic                  grant_i,
  output logic                  valid_o,
  output logic                  we_o,
  output logic [BusWidth-1:0]   addr_o,
  output logic [BusWidth-1:0]   wdata_o,
  output logic [BusWidth/8-1:0] be_o,
  output logic                  perr_o
);

  port_state_e           state_r, state_next_s;
  logic                  pending_s, load_s;
  logic                  held_we_r;
  logic [BusWidth-1:0]   held_addr_r, held_wdata_r;
  logic [BusWidth/8-1:0] held_be_r;

  // Candidate selection, protocol check and next port state
  always_comb begin
    pending_s    = (state_r == PENDING);
    valid_o      = pending_s | strobe_i;
    perr_o       = pending_s & strobe_i;
    load_s       = strobe_i & ~pending_s & ~grant_i;
    state_next_s = EMPTY;
    if (pending_s) begin
      we_o    = held_we_r;
      addr_o  = held_addr_r;
      wdata_o = held_wdata_r;
      be_o    = held_be_r;
    end else begin
      we_o    = we_i;
      addr_o  = addr_i;
      wdata_o = wdata_i;
      be_o    = be_i;
    end
    // A strobe hitting a full slot is dropped; the held request keeps its place
    if (grant_i) begin
      state_next_s = INFLIGHT;
    end else if (pending_s || strobe_i) begin
      state_next_s = PENDING;
    end else begin
      state_next_s = EMPTY;
    end
  end

  // Port state and held request registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r      <= EMPTY;
      held_we_r    <= 1'b0;
      held_addr_r  <= {BusWidth{1'b0}};
      held_wdata_r <= {BusWidth{1'b0}};
      held_be_r    <= {(BusWidth/8){1'b0}};
    end else begin
      state_r <= state_next_s;
      if (load_s) begin
        held_we_r    <= we_i;
        held_addr_r  <= addr_i;
        held_wdata_r <= wdata_i;
        held_be_r    <= be_i;
      end
    end
  end

endmodule

// File: rtl/dm_mem_port_arbiter.sv
// Merges the core's instruction-fetch and data ports onto dm_mem's single slave port.
// Round-robin on ties, region check, and a one-stage response pipeline for the 1-cycle read latency.
module dm_mem_port_arbiter
  import dm_pkg::*;
#(
  parameter int unsigned         BusWidth      = 32,
  parameter logic [BusWidth-1:0] DmBaseAddress = {BusWidth{1'b0}}
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  ifetch_req_i,
  input  logic [BusWidth-1:0]   ifetch_addr_i,
  output logic                  ifetch_ready_o,
  output logic [BusWidth-1:0]   ifetch_rdata_o,
  input  logic                  dmem_req_i,
  input  logic                  dmem_we_i,
  input  logic [BusWidth-1:0]   dmem_addr_i,
  input  logic [BusWidth-1:0]   dmem_wdata_i,
  input  logic [BusWidth/8-1:0] dmem_be_i,
  output logic                  dmem_ready_o,
  output logic [BusWidth-1:0]   dmem_rdata_o,
  output logic                  req_o,
  output logic                  we_o,
  output logic [BusWidth-1:0]   addr_o,
  output logic [BusWidth-1:0]   wdata_o,
  output logic [BusWidth/8-1:0] be_o,
  input  logic [BusWidth-1:0]   rdata_i,
  output logic                  err_o
);

  logic                  if_valid_s, if_we_s, if_perr_s, if_grant_s;
  logic [BusWidth-1:0]   if_addr_s, if_wdata_s;
  logic [BusWidth/8-1:0] if_be_s;
  logic                  dm_valid_s, dm_we_s, dm_perr_s, dm_grant_s;
  logic [BusWidth-1:0]   dm_addr_s, dm_wdata_s;
  logic [BusWidth/8-1:0] dm_be_s;

  grant_e                sel_s, last_grant_r, rsp_owner_r;
  logic                  gnt_valid_s, in_region_s, issue_s;
  logic                  g_we_s;
  logic [BusWidth-1:0]   g_addr_s, g_wdata_s, offset_s;
  logic [BusWidth/8-1:0] g_be_s;
  logic                  rsp_valid_r, rsp_read_r, rsp_oor_r;

  dm_req_slot #(.BusWidth(BusWidth)) u_ifetch_slot (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .strobe_i (ifetch_req_i),
    .we_i     (1'b0),
    .addr_i   (ifetch_addr_i),
    .wdata_i  ({BusWidth{1'b0}}),
    .be_i     ({(BusWidth/8){1'b1}}),
    .grant_i  (if_grant_s),
    .valid_o  (if_valid_s),
    .we_o     (if_we_s),
    .addr_o   (if_addr_s),
    .wdata_o  (if_wdata_s),
    .be_o     (if_be_s),
    .perr_o   (if_perr_s)
  );

  dm_req_slot #(.BusWidth(BusWidth)) u_dmem_slot (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .strobe_i (dmem_req_i),
    .we_i     (dmem_we_i),
    .addr_i   (dmem_addr_i),
    .wdata_i  (dmem_wdata_i),
    .be_i     (dmem_be_i),
    .grant_i  (dm_grant_s),
    .valid_o  (dm_valid_s),
    .we_o     (dm_we_s),
    .addr_o   (dm_addr_s),
    .wdata_o  (dm_wdata_s),
    .be_o     (dm_be_s),
    .perr_o   (dm_perr_s)
  );

  // Grant selection, region check and issue to dm_mem
  always_comb begin
    if (if_valid_s && dm_valid_s) begin
      sel_s = (last_grant_r == GNT_IFETCH) ? GNT_DMEM : GNT_IFETCH;
    end else if (dm_valid_s) begin
      sel_s = GNT_DMEM;
    end else begin
      sel_s = GNT_IFETCH;
    end
    gnt_valid_s = (if_valid_s | dm_valid_s) & ~rst_i;
    if_grant_s  = gnt_valid_s & (sel_s == GNT_IFETCH);
    dm_grant_s  = gnt_valid_s & (sel_s == GNT_DMEM);
    if (sel_s == GNT_DMEM) begin
      g_we_s    = dm_we_s;
      g_addr_s  = dm_addr_s;
      g_wdata_s = dm_wdata_s;
      g_be_s    = dm_be_s;
    end else begin
      g_we_s    = if_we_s;
      g_addr_s  = if_addr_s;
      g_wdata_s = if_wdata_s;
      g_be_s    = if_be_s;
    end
    // Unsigned offset makes addresses below the base wrap and fail the check too
    offset_s    = g_addr_s - DmBaseAddress;
    in_region_s = (offset_s < DM_REGION_SIZE);
    issue_s     = gnt_valid_s & in_region_s;
    req_o       = issue_s;
    we_o        = issue_s & g_we_s;
    addr_o      = issue_s ? g_addr_s  : {BusWidth{1'b0}};
    wdata_o     = issue_s ? g_wdata_s : {BusWidth{1'b0}};
    be_o        = issue_s ? g_be_s    : {(BusWidth/8){1'b0}};
  end

  // Response routing to the owning master and error merge
  always_comb begin
    ifetch_ready_o = rsp_valid_r & ~rst_i & (rsp_owner_r == GNT_IFETCH);
    dmem_ready_o   = rsp_valid_r & ~rst_i & (rsp_owner_r == GNT_DMEM);
    if (ifetch_ready_o && rsp_read_r) begin
      ifetch_rdata_o = rdata_i;
    end else begin
      ifetch_rdata_o = {BusWidth{1'b0}};
    end
    if (dmem_ready_o && rsp_read_r) begin
      dmem_rdata_o = rdata_i;
    end else begin
      dmem_rdata_o = {BusWidth{1'b0}};
    end
    err_o = ~rst_i & ((rsp_valid_r & rsp_oor_r) | if_perr_s | dm_perr_s);
  end

  // Round-robin history and in-flight owner pipeline
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_grant_r <= GNT_DMEM;
      rsp_owner_r  <= GNT_IFETCH;
      rsp_valid_r  <= 1'b0;
      rsp_read_r   <= 1'b0;
      rsp_oor_r    <= 1'b0;
    end else begin
      rsp_valid_r <= gnt_valid_s;
      rsp_owner_r <= sel_s;
      rsp_read_r  <= issue_s & ~g_we_s;
      rsp_oor_r   <= gnt_valid_s & ~in_region_s;
      if (gnt_valid_s) begin
        last_grant_r <= sel_s;
      end else begin
        last_grant_r <= last_grant_r;
      end
    end
  end

endmodule

// File: tb/tb_dm_mem_port_arbiter.sv
// Self-checking bench for dm_mem_port_arbiter: a per-cycle behavioural model plus
// hand-computed literal expectations pinned on the directed scenarios.
module tb_dm_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata;
  logic [3:0]  dm_be;
  logic        if_ready, dm_ready, req, we, err;
  logic [31:0] if_rdata, dm_rdata, addr, wdata, rdata;
  logic [3:0]  be;

  int errors = 0;
  int checks = 0;

  // literal pins: 0 req,1 we,2 addr,3 wdata,4 be,5 if_ready,6 if_rdata,7 dm_ready,8 dm_rdata,9 err
  bit          lit_en [10];
  logic [31:0] lit_v  [10];
  string       nm     [10] = '{"req_o", "we_o", "addr_o", "wdata_o", "be_o",
                               "ifetch_ready_o", "ifetch_rdata_o", "dmem_ready_o",
                               "dmem_rdata_o", "err_o"};

  always #5 clk = ~clk;

  dm_mem_port_arbiter #(.BusWidth(32), .DmBaseAddress(32'h0000_0000)) dut (
    .clk_i(clk), .rst_i(rst),
    .ifetch_req_i(if_req), .ifetch_addr_i(if_addr),
    .ifetch_ready_o(if_ready), .ifetch_rdata_o(if_rdata),
    .dmem_req_i(dm_req), .dmem_we_i(dm_we), .dmem_addr_i(dm_addr),
    .dmem_wdata_i(dm_wdata), .dmem_be_i(dm_be),
    .dmem_ready_o(dm_ready), .dmem_rdata_o(dm_rdata),
    .req_o(req), .we_o(we), .addr_o(addr), .wdata_o(wdata), .be_o(be),
    .rdata_i(rdata), .err_o(err)
  );

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a == 32'h0000_0800) ? 32'h0180_006F : (a ^ 32'hA5A5_0000);
  endfunction

  // dm_mem stand-in: data one cycle after a read, garbage otherwise
  always @(posedge clk) begin
    if (req && !we) rdata <= mem_fn(addr);
    else            rdata <= 32'hDEAD_BEEF;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // model state: slots per port (0 ifetch, 1 dmem), round-robin history, response in flight
  bit        m_full [2], n_full [2];
  bit        m_we [2], n_we [2];
  bit [31:0] m_addr [2], n_addr [2], m_wd [2], n_wd [2];
  bit [3:0]  m_be [2], n_be [2];
  bit        m_last, n_last, m_rv, n_rv, m_ro, n_ro, m_rrd, n_rrd, m_roor, n_roor;
  bit [31:0] m_raddr, n_raddr;

  always @(posedge clk) begin
    m_full <= n_full; m_we <= n_we; m_addr <= n_addr; m_wd <= n_wd; m_be <= n_be;
    m_last <= n_last; m_rv <= n_rv; m_ro <= n_ro; m_rrd <= n_rrd;
    m_roor <= n_roor; m_raddr <= n_raddr;
  end

  // compare process: model predicts every output each cycle
  always @(negedge clk) begin
    logic [31:0] e [10];
    logic [31:0] a [10];
    bit          cv [2], cwe [2];
    bit [31:0]   ca [2], cwd [2];
    bit [3:0]    cbe [2];
    bit          w, oor;
    for (int i = 0; i < 10; i++) e[i] = 32'h0;
    n_full = m_full; n_we = m_we; n_addr = m_addr; n_wd = m_wd; n_be = m_be;
    n_last = m_last; n_rv = 1'b0; n_ro = m_ro; n_rrd = 1'b0; n_roor = 1'b0; n_raddr = m_raddr;
    if (rst) begin
      n_full = '{1'b0, 1'b0};
      n_last = 1'b1;
    end else begin
      if (m_rv) begin
        if (m_ro) begin
          e[7] = 32'h1; e[8] = m_rrd ? mem_fn(m_raddr) : 32'h0;
        end else begin
          e[5] = 32'h1; e[6] = m_rrd ? mem_fn(m_raddr) : 32'h0;
        end
        if (m_roor) e[9] = 32'h1;
      end
      cv[0] = m_full[0] | if_req;
      cwe[0] = 1'b0; cwd[0] = 32'h0; cbe[0] = 4'hF;
      ca[0] = m_full[0] ? m_addr[0] : if_addr;
      cv[1] = m_full[1] | dm_req;
      cwe[1] = m_full[1] ? m_we[1] : dm_we;
      ca[1]  = m_full[1] ? m_addr[1] : dm_addr;
      cwd[1] = m_full[1] ? m_wd[1] : dm_wdata;
      cbe[1] = m_full[1] ? m_be[1] : dm_be;
      if ((m_full[0] && if_req) || (m_full[1] && dm_req)) e[9] = 32'h1;
      if (cv[0] || cv[1]) begin
        w = (cv[0] && cv[1]) ? !m_last : cv[1];
        oor = (ca[w] >= 32'h0000_1000);
        if (!oor) begin
          e[0] = 32'h1; e[1] = {31'h0, cwe[w]}; e[2] = ca[w]; e[3] = cwd[w]; e[4] = {28'h0, cbe[w]};
        end
        n_rv = 1'b1; n_ro = w; n_rrd = !oor && !cwe[w]; n_roor = oor; n_raddr = ca[w]; n_last = w;
        for (int p = 0; p < 2; p++) begin
          if (p == int'(w)) n_full[p] = 1'b0;
          else if (cv[p]) begin
            n_full[p] = 1'b1; n_we[p] = cwe[p]; n_addr[p] = ca[p]; n_wd[p] = cwd[p]; n_be[p] = cbe[p];
          end
        end
      end
    end
    a[0] = {31'h0, req}; a[1] = {31'h0, we}; a[2] = addr; a[3] = wdata; a[4] = {28'h0, be};
    a[5] = {31'h0, if_ready}; a[6] = if_rdata; a[7] = {31'h0, dm_ready}; a[8] = dm_rdata;
    a[9] = {31'h0, err};
    for (int i = 0; i < 10; i++) begin
      chk(nm[i], a[i], e[i]);
      if (lit_en[i]) chk({"lit_", nm[i]}, a[i], lit_v[i]);
    end
  end

  task automatic pin(input int idx, input logic [31:0] v);
    lit_en[idx] = 1'b1;
    lit_v[idx]  = v;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if_req = 1'b0; dm_req = 1'b0;
    for (int i = 0; i < 10; i++) lit_en[i] = 1'b0;
  endtask

  task automatic dmem(input logic w, input logic [31:0] ad, input logic [31:0] wd);
    dm_req = 1'b1; dm_we = w; dm_addr = ad; dm_wdata = wd; dm_be = 4'hF;
  endtask

  initial begin
    logic [31:0] iv;
    rst = 1'b1; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
    if_addr = 32'h0; dm_addr = 32'h0; dm_wdata = 32'h0; dm_be = 4'h0;
    for (int i = 0; i < 10; i++) begin lit_en[i] = 1'b0; lit_v[i] = 32'h0; end
    pin(0, 32'h0); pin(7, 32'h0); pin(9, 32'h0);
    repeat (3) tick();
    rst = 1'b0;
    // tie right after reset: ifetch wins, dmem held
    if_req = 1'b1; if_addr = 32'h300; dmem(1'b1, 32'h100, 32'h0);
    pin(0, 32'h1); pin(2, 32'h300); pin(7, 32'h0); tick();
    // fresh ifetch vs held dmem: dmem wins this time
    if_req = 1'b1; if_addr = 32'h304;
    pin(5, 32'h1); pin(2, 32'h100); pin(1, 32'h1); pin(7, 32'h0); tick();
    pin(7, 32'h1); pin(2, 32'h304); tick();
    pin(5, 32'h1); pin(6, 32'hA5A5_0304); tick();
    tick();
    // single ifetch read of 0x800
    if_req = 1'b1; if_addr = 32'h800; pin(0, 32'h1); pin(2, 32'h800); tick();
    pin(5, 32'h1); pin(6, 32'h0180_006F); tick();
    tick();
    // tie with ifetch last granted, then strobe on the pending ifetch slot
    if_req = 1'b1; if_addr = 32'h310; dmem(1'b0, 32'h200, 32'h0);
    pin(2, 32'h200); pin(1, 32'h0); tick();
    if_req = 1'b1; if_addr = 32'h314;
    pin(9, 32'h1); pin(2, 32'h310); pin(7, 32'h1); pin(8, 32'hA5A5_0200); tick();
    pin(5, 32'h1); pin(6, 32'hA5A5_0310); pin(9, 32'h0); tick();
    pin(5, 32'h0); pin(0, 32'h0); tick();
    // back-to-back dmem writes
    dmem(1'b1, 32'h380, 32'h1111_1111); pin(0, 32'h1); pin(2, 32'h380); tick();
    dmem(1'b1, 32'h384, 32'h2222_2222); pin(0, 32'h1); pin(2, 32'h384); pin(3, 32'h2222_2222); pin(7, 32'h1); tick();
    pin(7, 32'h1); pin(8, 32'h0); pin(0, 32'h0); tick();
    pin(7, 32'h0); tick();
    // out-of-region read
    dmem(1'b0, 32'h1000, 32'h0); pin(0, 32'h0); tick();
    pin(7, 32'h1); pin(8, 32'h0); pin(9, 32'h1); tick();
    tick();
    // reset the cycle after an issue
    dmem(1'b0, 32'h204, 32'h0); pin(0, 32'h1); tick();
    rst = 1'b1; pin(7, 32'h0); pin(0, 32'h0); pin(9, 32'h0); tick();
    rst = 1'b0; dmem(1'b0, 32'h208, 32'h0); pin(0, 32'h1); pin(2, 32'h208); tick();
    pin(7, 32'h1); pin(8, 32'hA5A5_0208); tick();
    // mixed traffic table including region edges and protocol errors
    for (int i = 0; i < 24; i++) begin
      iv = i;
      if_req = (i % 3) != 1;
      if_addr = 32'h400 + iv * 32'h4;
      dm_req = (i % 4) != 3;
      dm_we = iv[0];
      dm_addr = (i % 5 == 0) ? 32'h1000 + iv * 32'h4 : ((i % 5 == 1) ? 32'hFFC : 32'h200 + iv * 32'h4);
      dm_wdata = iv * 32'h0101_0101;
      dm_be = iv[3:0];
      tick();
    end
    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
